// File: rtl/fpu_sched_pkg.sv
// rtl/fpu_sched_pkg.sv - shared widths and types for the fpu adder scheduler
package fpu_sched_pkg;

    localparam int FP_W  = 32;
    localparam int CNT_W = 16;

    typedef logic [FP_W-1:0] fp32_t;

endpackage

// File: rtl/fpu.sv
// rtl/fpu.sv - combinational IEEE-754 single-precision adder, round-to-nearest-even
module fpu
    import fpu_sched_pkg::*;
(
    input  fp32_t a_i,
    input  fp32_t b_i,
    output fp32_t sum_o
);

    logic               sa, sb, sl, ss;
    logic [7:0]         ea, eb, el, es, d;
    logic [23:0]        ma, mb;
    logic               a_nan, b_nan, a_inf, b_inf, swap;
    logic [26:0]        mx, my0, my_sh, n;
    logic [27:0]        s;
    logic signed [9:0]  e;
    logic [24:0]        mr;
    logic               rnd;
    int                 lz;

    always_comb begin
        sum_o = '0;
        sa    = a_i[31];
        sb    = b_i[31];
        ea    = a_i[30:23];
        eb    = b_i[30:23];
        // Subnormal inputs are flushed to zero.
        ma    = (ea == 8'd0) ? 24'd0 : {1'b1, a_i[22:0]};
        mb    = (eb == 8'd0) ? 24'd0 : {1'b1, b_i[22:0]};
        a_nan = (ea == 8'hFF) && (a_i[22:0] != 23'd0);
        b_nan = (eb == 8'hFF) && (b_i[22:0] != 23'd0);
        a_inf = (ea == 8'hFF) && (a_i[22:0] == 23'd0);
        b_inf = (eb == 8'hFF) && (b_i[22:0] == 23'd0);

        swap  = {eb, mb} > {ea, ma};
        sl    = swap ? sb : sa;
        ss    = swap ? sa : sb;
        el    = swap ? eb : ea;
        es    = swap ? ea : eb;
        mx    = {(swap ? mb : ma), 3'b000};
        my0   = {(swap ? ma : mb), 3'b000};
        d     = el - es;

        // Bits shifted out of the smaller operand fold into a sticky LSB.
        if (d >= 8'd27) begin
            my_sh = {26'd0, |my0};
        end else begin
            my_sh    = my0 >> d;
            my_sh[0] = my_sh[0] | (|(my0 & ((27'd1 << d) - 27'd1)));
        end

        if (sl == ss) s = {1'b0, mx} + {1'b0, my_sh};
        else          s = {1'b0, mx} - {1'b0, my_sh};

        e = {2'b00, el};
        if (s[27]) begin
            n = s[27:1] | {26'd0, s[0]};
            e = e + 10'sd1;
        end else begin
            n = s[26:0];
        end

        lz = 27;
        for (int i = 0; i < 27; i++) begin
            if (n[i]) lz = 26 - i;
        end
        if (lz < 27) begin
            n = n << lz;
            e = e - 10'(lz);
        end

        rnd = n[2] & (n[1] | n[0] | n[3]);
        mr  = {1'b0, n[26:3]} + {24'd0, rnd};
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 10'sd1;
        end

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            sum_o = 32'h7FC0_0000;
        end else if (a_inf) begin
            sum_o = {sa, 8'hFF, 23'd0};
        end else if (b_inf) begin
            sum_o = {sb, 8'hFF, 23'd0};
        end else if (mx == 27'd0) begin
            sum_o = {sa & sb, 31'd0};
        end else if (lz == 27) begin
            sum_o = 32'd0;
        end else if (e >= 10'sd255) begin
            sum_o = {sl, 8'hFF, 23'd0};
        end else if (e <= 10'sd0) begin
            sum_o = {sl, 31'd0};
        end else begin
            sum_o = {sl, e[7:0], mr[22:0]};
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter; grants the first request at or after ptr
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_oh,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    int idx;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx]) begin
                any         = 1'b1;
                gnt_idx     = IW'(idx);
                gnt_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_add_sched.sv
// rtl/fpu_add_sched.sv - round-robin scheduler feeding one shared fpu adder through a two-stage pipeline
module fpu_add_sched
    import fpu_sched_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [FP_W*N_REQ-1:0] req_a,
    input  logic [FP_W*N_REQ-1:0] req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output fp32_t                 res_data,
    output logic [ID_W-1:0]       res_id,
    output logic                  busy,
    output logic [CNT_W-1:0]      op_count
);

    logic             s1_valid_q, s1_valid_d;
    fp32_t            s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [ID_W-1:0]  s1_id_q, s1_id_d;
    logic             res_valid_q, res_valid_d;
    fp32_t            res_data_q, res_data_d;
    logic [ID_W-1:0]  res_id_q, res_id_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic             adv1, adv2;
    logic [N_REQ-1:0] gnt_oh;
    logic [ID_W-1:0]  gnt_idx;
    logic             gnt_any;
    fp32_t            fpu_sum;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    fpu u_fpu (
        .a_i   (s1_a_q),
        .b_i   (s1_b_q),
        .sum_o (fpu_sum)
    );

    always_comb begin
        adv2        = s1_valid_q & (~res_valid_q | res_ready);
        adv1        = ~s1_valid_q | adv2;
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_id_d     = s1_id_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        rr_ptr_d    = rr_ptr_q;
        op_count_d  = op_count_q + CNT_W'(res_valid_q & res_ready);
        // Ready is forced low while reset is held so no handshake can be seen during reset.
        req_ready   = (adv1 && !rst) ? gnt_oh : '0;

        if (adv1) begin
            s1_valid_d = gnt_any;
            if (gnt_any) begin
                s1_a_d   = req_a[FP_W*gnt_idx +: FP_W];
                s1_b_d   = req_b[FP_W*gnt_idx +: FP_W];
                s1_id_d  = gnt_idx;
                rr_ptr_d = (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
            end
        end

        if (adv2) begin
            res_valid_d = 1'b1;
            res_data_d  = fpu_sum;
            res_id_d    = s1_id_q;
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            rr_ptr_q    <= '0;
            op_count_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_id_q     <= s1_id_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            rr_ptr_q    <= rr_ptr_d;
            op_count_q  <= op_count_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = s1_valid_q | res_valid_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_fpu_add_sched.sv
// tb/tb_fpu_add_sched.sv - directed vector bench for fpu_add_sched
module tb_fpu_add_sched;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_a = '0;
    logic [32*N-1:0] req_b = '0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [31:0]     res_data;
    logic [1:0]      res_id;
    logic            busy;
    logic [15:0]     op_count;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_ops = '0;
    int          accepts;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
    } vec_t;

    vec_t        vecs [12];
    logic [31:0] fair_sum [4];

    fpu_add_sched #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b);
        req_a[32*r +: 32] = a;
        req_b[32*r +: 32] = b;
    endtask

    task automatic run_one(input int r, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] s);
        set_req(r, a, b);
        req_valid    = '0;
        req_valid[r] = 1'b1;
        res_ready    = 1'b1;
        at_neg();
        check("one_ready", 32'(req_ready), 32'(1 << r));
        tick();
        req_valid = '0;
        at_neg();
        check("one_latency_valid", 32'(res_valid), 32'd0);
        check("one_busy", 32'(busy), 32'd1);
        tick();
        at_neg();
        check("one_res_valid", 32'(res_valid), 32'd1);
        check("one_res_id", 32'(res_id), 32'(r));
        check("one_res_data", res_data, s);
        tick();
        exp_ops++;
        at_neg();
        check("one_op_count", 32'(op_count), 32'(exp_ops));
        check("one_drained", 32'(res_valid), 32'd0);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        tick();
        rst = 1'b0;
        exp_ops = '0;
    endtask

    initial begin
        vecs[0]  = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
        vecs[1]  = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000};
        vecs[2]  = '{32'h4049_0FDB, 32'h0000_0000, 32'h4049_0FDB};
        vecs[3]  = '{32'h3FC0_0000, 32'h3FC0_0000, 32'h4040_0000};
        vecs[4]  = '{32'h4120_0000, 32'hC0A0_0000, 32'h40A0_0000};
        vecs[5]  = '{32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000};
        vecs[6]  = '{32'h3F80_0000, 32'h3380_0001, 32'h3F80_0001};
        vecs[7]  = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000};
        vecs[8]  = '{32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000};
        vecs[9]  = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000};
        vecs[10] = '{32'hC040_0000, 32'h3F80_0000, 32'hC000_0000};
        vecs[11] = '{32'h3F80_0001, 32'hBF80_0000, 32'h3400_0000};
        fair_sum[0] = 32'h3F80_0000;
        fair_sum[1] = 32'h4000_0000;
        fair_sum[2] = 32'h4040_0000;
        fair_sum[3] = 32'h4080_0000;

        // Reset with toggling inputs: every output must read zero.
        for (int c = 0; c < 4; c++) begin
            req_valid = 4'($urandom);
            req_a     = {$urandom, $urandom, $urandom, $urandom};
            req_b     = {$urandom, $urandom, $urandom, $urandom};
            res_ready = 1'($urandom);
            at_neg();
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_res_valid", 32'(res_valid), 32'd0);
            check("rst_res_data", res_data, 32'd0);
            check("rst_res_id", 32'(res_id), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_op_count", 32'(op_count), 32'd0);
            tick();
        end
        rst = 1'b0;
        req_valid = 4'b0001;
        res_ready = 1'b0;
        at_neg();
        check("post_rst_ready", 32'(req_ready), 32'd1);
        #1;
        do_reset();

        run_one(2, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
        for (int i = 0; i < 12; i++) begin
            run_one(i % N, vecs[i].a, vecs[i].b, vecs[i].s);
        end

        // Fairness: all requesters valid, grant order 0,1,2,3,...
        do_reset();
        for (int r = 0; r < N; r++) set_req(r, 32'h3F80_0000, (r == 0) ? 32'd0 : fair_sum[r-1]);
        req_valid = 4'b1111;
        res_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            at_neg();
            if (k < 8) check("fair_grant", 32'(req_ready), 32'(1 << (k % N)));
            if (k >= 2) begin
                check("fair_res_valid", 32'(res_valid), 32'd1);
                check("fair_res_id", 32'(res_id), 32'((k - 2) % N));
                check("fair_res_data", res_data, fair_sum[(k - 2) % N]);
            end
            tick();
            if (k == 7) req_valid = '0;
        end
        at_neg();
        check("fair_op_count", 32'(op_count), 32'd8);
        check("fair_idle", 32'(busy), 32'd0);
        tick();

        // Backpressure: two accepts fill both stages, then ready drops.
        accepts = 0;
        res_ready = 1'b0;
        set_req(1, 32'h4000_0000, 32'h4000_0000);
        set_req(3, 32'h4040_0000, 32'h4040_0000);
        req_valid = 4'b1010;
        at_neg();
        check("bp_grant1", 32'(req_ready), 32'b0010);
        accepts += $countones(req_valid & req_ready);
        tick();
        req_valid = 4'b1000;
        at_neg();
        check("bp_grant3", 32'(req_ready), 32'b1000);
        accepts += $countones(req_valid & req_ready);
        tick();
        set_req(1, 32'h3F80_0000, 32'h3F80_0000);
        req_valid = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            at_neg();
            accepts += $countones(req_valid & req_ready);
            check("bp_stall_ready", 32'(req_ready), 32'd0);
            check("bp_hold_valid", 32'(res_valid), 32'd1);
            check("bp_hold_id", 32'(res_id), 32'd1);
            check("bp_hold_data", res_data, 32'h4080_0000);
            tick();
        end
        check("bp_accepts", 32'(accepts), 32'd2);
        res_ready = 1'b1;
        at_neg();
        check("bp_release_ready", 32'(req_ready), 32'b0010);
        check("bp_out1_id", 32'(res_id), 32'd1);
        tick();
        req_valid = '0;
        at_neg();
        check("bp_out3_id", 32'(res_id), 32'd3);
        check("bp_out3_data", res_data, 32'h40C0_0000);
        tick();
        at_neg();
        check("bp_out1b_id", 32'(res_id), 32'd1);
        check("bp_out1b_data", res_data, 32'h4000_0000);
        tick();
        at_neg();
        check("bp_op_count", 32'(op_count), 32'd11);
        tick();

        // Asynchronous reset with both stages full.
        set_req(0, 32'h3F80_0000, 32'h3F80_0000);
        req_valid = 4'b0001;
        res_ready = 1'b0;
        tick();
        tick();
        at_neg();
        check("mid_pre_busy", 32'(busy), 32'd1);
        check("mid_pre_valid", 32'(res_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(res_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_rst_count", 32'(op_count), 32'd0);
        req_valid = '0;
        tick();
        rst = 1'b0;
        res_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            at_neg();
            check("mid_no_result", 32'(res_valid), 32'd0);
            tick();
        end

        // Counter wrap: 65535 streamed results, then one more.
        set_req(0, 32'd0, 32'd0);
        req_valid = 4'b0001;
        for (int c = 0; c < 65535; c++) tick();
        req_valid = '0;
        for (int c = 0; c < 4; c++) tick();
        at_neg();
        check("wrap_full", 32'(op_count), 32'h0000_FFFF);
        tick();
        exp_ops = 16'hFFFF;
        run_one(0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
        check("wrap_zero", 32'(op_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
